uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver. It consumes the 16x-oversample enable `rxclk_en` from the baud generator on the same `pclk` domain.
- Synchronises the asynchronous serial line, qualifies the start bit, samples each bit at mid-bit, checks the stop bit and presents the received byte with a ready flag.
- Sits between the board RX pin and the command/data consumer logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, `rxclk_en` ticks per bit period; must be even and at least 4.
- MID_SAMPLE, OVERSAMPLE/2-1, tick index (0-based) at which the start bit is re-checked.

Ports:
- pclk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rxclk_en  in  1  one-`pclk`-wide oversample strobe from the baud generator.
- rx  in  1  asynchronous serial input; idles high.
- rdy_clr  in  1  consumer acknowledge; clears `rdy` and `overrun`.
- data  out  DATA_BITS  last received byte.
- rdy  out  1  byte available.
- frame_err  out  1  stop bit of the last frame sampled low.
- overrun  out  1  a byte completed while `rdy` was already set.

Behaviour:
- Reset (`rst_n`=0 at a `pclk` edge):
  - state=IDLE; sync flops=1; tick counter=0; bit counter=0; shift register=0.
  - `data`=0, `rdy`=0, `frame_err`=0, `overrun`=0.
  - Reset mid-frame aborts the frame silently.
- Input synchroniser: 2 flops, giving `rx_s`. All decisions use `rx_s`, which lags `rx` by 2 `pclk`.
- State and counter updates occur only on cycles with `rxclk_en`=1, except for the `rdy_clr` handling.
- IDLE: when `rx_s`=0 → START with tick=0.
- START:
  - Tick increments each enable.
  - At tick=MID_SAMPLE: if `rx_s`=0 → DATA with tick=0 and bit=0; otherwise treat as a glitch → IDLE with no output change.
- DATA:
  - At tick=OVERSAMPLE-1, sample `rx_s` into the shift register MSB, shifting right so the result is LSB-first.
  - Tick → 0 and bit increments.
  - After bit DATA_BITS-1 is sampled → STOP (PARITY when the optional feature is on).
- STOP: at tick=OVERSAMPLE-1, sample `rx_s`.
  - If 1: `data`<=shift, `rdy`<=1, `frame_err`<=0; if `rdy` was already 1 and `rdy_clr`=0 in that cycle, `overrun`<=1. Next state IDLE.
  - If 0: `frame_err`<=1; `data` and `rdy` are unchanged. Next state WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then → IDLE. This prevents a break condition from retriggering.
- `rdy_clr`=1 in any cycle, independent of `rxclk_en`: `rdy`<=0 and `overrun`<=0. `frame_err` is unaffected.
- Simultaneous byte completion and `rdy_clr`: the set wins, so `rdy`=1, and `overrun` is not set.
- `data` is stable whenever `rdy`=1, except that it is overwritten by a subsequent byte (flagged by `overrun`).
- Latency: `rdy` rises at the `pclk` edge of the stop-bit sample enable, about 9.5 bit periods after the start-bit falling edge, plus 2 `pclk`.
- Counter widths: tick is $clog2(OVERSAMPLE) bits; bit is $clog2(DATA_BITS+1) bits. No wrap beyond the stated terminal values.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds an output `parity_err` (1 bit, reset 0) and a PARITY state between DATA and STOP.
  - The parity bit is sampled at tick=OVERSAMPLE-1. Even parity: `parity_err`<=(XOR of data bits) ^ sample.
  - `parity_err` is updated on every frame that reaches STOP; the byte is still delivered.
- When undefined: no port, no state, 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH as a 3-bit localparam set;
  - default DATA_BITS and OVERSAMPLE constants, shared with the future uart_tx.
- One natural sub-module, sync_2ff: the 2-flop synchroniser with reset value 1.

Test Plan:
- Bench setup: `pclk` with `rxclk_en` every 4 cycles. Drive 0xA5 as 8N1 → `data`=0xA5 and `rdy`=1 at the stop sample; `frame_err`=0, `overrun`=0.
- `rx` low for 3 enable ticks, then high → state returns to IDLE; `rdy` stays 0; the next valid frame 0x3C is received correctly.
- Frame 0x3C with stop bit driven 0, then held low 40 ticks → `frame_err`=1, `rdy`=0, `data` unchanged. After `rx` returns high, frame 0x5A is received with `frame_err`=0.
- Frames 0x11 then 0x22 with no `rdy_clr` → `data`=0x22, `rdy`=1, `overrun`=1. Pulse `rdy_clr` → `rdy`=0, `overrun`=0. Pulsing `rdy_clr` on the completion edge of a third frame leaves `rdy`=1 and `overrun`=0.
- Assert `rst_n`=0 during bit 4 of 0xFF → all outputs 0 next edge. A following frame 0x81 decodes correctly.
- With UART_RX_PARITY_EN: 0x07 sent with parity bit 1 → `parity_err`=0; sent with parity bit 0 → `parity_err`=1 and `data`=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding (also intended for uart_tx).
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 by default).
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MID_SAMPLE = OVERSAMPLE / 2 - 1
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy, r_ferr, r_ovr;
  logic                 w_done, w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr, w_perr_upd;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk  (pclk),
    .i_rst_n(rst_n),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_upd  = 1'b0;
`endif
    if (rxclk_en) begin
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = START;
            w_tick_nxt  = '0;
          end
        end
        START: begin
          // Re-check mid start bit; a line already high again was a glitch.
          if (r_tick == TICK_MID) begin
            w_tick_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        DATA: begin
          if (r_tick == TICK_LAST) begin
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_tick_nxt  = '0;
            w_bit_nxt   = r_bit + BW'(1);
            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_tick == TICK_LAST) begin
            w_perr_upd  = 1'b1;
            w_tick_nxt  = '0;
            w_state_nxt = STOP;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
`endif
        STOP: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt = '0;
            if (w_rx_s) begin
              w_done      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = WAIT_HIGH;
            end
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
        end
        // A held-low line (break) must not be mistaken for a new start bit.
        WAIT_HIGH: begin
          if (w_rx_s) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      // A completing byte outranks a same-cycle acknowledge.
      if (w_done) begin
        r_data <= r_shift;
        r_rdy  <= 1'b1;
        r_ferr <= 1'b0;
        if (r_rdy && !rdy_clr) r_ovr <= 1'b1;
        else if (rdy_clr)      r_ovr <= 1'b0;
      end else begin
        if (w_ferr_set) r_ferr <= 1'b1;
        if (rdy_clr) begin
          r_rdy <= 1'b0;
          r_ovr <= 1'b0;
        end
      end
`ifdef UART_RX_PARITY_EN
      if (w_perr_upd) r_perr <= (^r_shift) ^ w_rx_s;
`endif
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule
